// File: rtl/decode_fwd.sv
// RV32I-style decode stage with valid/ready handshakes, writeback forwarding, load-use interlock
// and a saturating stall counter. Define DECODE_ILLEGAL_TRAP_EN to add the ex_illegal output.
module decode_fwd #(
  parameter int XLEN        = 32,
  parameter int FWD_PORTS   = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [XLEN-1:0]           if_pc,
  input  logic [XLEN-1:0]           if_pcp4,
  input  logic [31:0]               if_inst,
  output logic [4:0]                rs1_addr,
  output logic [4:0]                rs2_addr,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic [FWD_PORTS-1:0]      wb_we,
  input  logic [5*FWD_PORTS-1:0]    wb_rd,
  input  logic [XLEN*FWD_PORTS-1:0] wb_data,
  input  logic                      ex_is_load,
  input  logic [4:0]                ex_rd,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_pcp4,
  output logic [XLEN-1:0]           ex_imm,
  output logic [XLEN-1:0]           ex_rs1_data,
  output logic [XLEN-1:0]           ex_rs2_data,
  output logic [31:0]               ex_inst,
  output logic [6:0]                ex_funct7,
  output logic [4:0]                ex_wreg,
  output logic [3:0]                ex_alu_fn,
  output logic                      ex_regwrite,
  output logic [1:0]                ex_memtoreg,
  output logic [1:0]                ex_memrw,
  output logic [2:0]                ex_membranch,
  output logic [2:0]                ex_alu_ctrl,
  output logic [2:0]                ex_alu_src,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                      ex_illegal,
`endif
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_PCP4 = 2'b10;

  localparam logic [1:0] MRW_NONE  = 2'b00;
  localparam logic [1:0] MRW_WRITE = 2'b01;
  localparam logic [1:0] MRW_READ  = 2'b10;

  localparam logic [2:0] MB_NONE = 3'b000;
  localparam logic [2:0] MB_EQ   = 3'b001;
  localparam logic [2:0] MB_NE   = 3'b010;
  localparam logic [2:0] MB_LT   = 3'b011;
  localparam logic [2:0] MB_GE   = 3'b100;
  localparam logic [2:0] MB_JAL  = 3'b110;
  localparam logic [2:0] MB_JALR = 3'b111;

  localparam logic [2:0] AC_NORMAL  = 3'b000;
  localparam logic [2:0] AC_COMPARE = 3'b001;
  localparam logic [2:0] AC_NOALU   = 3'b010;
  localparam logic [2:0] AC_JUMP    = 3'b011;
  localparam logic [2:0] AC_LOAD    = 3'b101;
  localparam logic [2:0] AC_STORE   = 3'b110;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_field;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_wreg;
  logic [3:0]      dec_alu_fn;
  logic            dec_regwrite;
  logic [1:0]      dec_memtoreg;
  logic [1:0]      dec_memrw;
  logic [2:0]      dec_membranch;
  logic [2:0]      dec_alu_ctrl;
  logic [2:0]      dec_alu_src;

  logic uses_rs2, hazard, hold, accept;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, ref_rs1, ref_rs2;

  logic                   ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]        ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]        ex_pcp4_q, ex_pcp4_d;
  logic [XLEN-1:0]        ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]        ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]        ex_rs2_data_q, ex_rs2_data_d;
  logic [31:0]            ex_inst_q, ex_inst_d;
  logic [6:0]             ex_funct7_q, ex_funct7_d;
  logic [4:0]             ex_wreg_q, ex_wreg_d;
  logic [3:0]             ex_alu_fn_q, ex_alu_fn_d;
  logic                   ex_regwrite_q, ex_regwrite_d;
  logic [1:0]             ex_memtoreg_q, ex_memtoreg_d;
  logic [1:0]             ex_memrw_q, ex_memrw_d;
  logic [2:0]             ex_membranch_q, ex_membranch_d;
  logic [2:0]             ex_alu_ctrl_q, ex_alu_ctrl_d;
  logic [2:0]             ex_alu_src_q, ex_alu_src_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Lowest-index matching writeback port wins; x0 always reads as zero.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [4:0]                rs,
    input logic [XLEN-1:0]           fallback,
    input logic [FWD_PORTS-1:0]      we,
    input logic [5*FWD_PORTS-1:0]    rd,
    input logic [XLEN*FWD_PORTS-1:0] data
  );
    logic [XLEN-1:0] r;
    r = fallback;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (we[i] && (rd[5*i +: 5] == rs)) r = data[XLEN*i +: XLEN];
    end
    if (rs == 5'd0) r = '0;
    return r;
  endfunction

  assign opcode   = if_inst[6:0];
  assign funct3   = if_inst[14:12];
  assign rd_field = if_inst[11:7];
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  assign imm_i = XLEN'($signed(if_inst[31:20]));
  assign imm_s = XLEN'($signed({if_inst[31:25], if_inst[11:7]}));
  assign imm_b = XLEN'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({if_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0}));

  always_comb begin
    dec_imm       = '0;
    dec_wreg      = rd_field;
    dec_alu_fn    = 4'b0000;
    dec_regwrite  = 1'b0;
    dec_memtoreg  = MTR_ALU;
    dec_memrw     = MRW_NONE;
    dec_membranch = MB_NONE;
    dec_alu_ctrl  = AC_NORMAL;
    dec_alu_src   = 3'b000;
    case (opcode)
      OP_LUI: begin
        dec_imm      = imm_u;
        dec_regwrite = 1'b1;
        dec_alu_ctrl = AC_NOALU;
      end
      OP_AUIPC: begin
        dec_alu_src  = 3'b100;
        dec_imm      = imm_u;
        dec_regwrite = 1'b1;
      end
      OP_JAL: begin
        dec_alu_src   = 3'b100;
        dec_imm       = imm_j;
        dec_regwrite  = 1'b1;
        dec_memtoreg  = MTR_PCP4;
        dec_membranch = MB_JAL;
        dec_alu_ctrl  = AC_JUMP;
      end
      OP_JALR: begin
        dec_alu_src   = 3'b010;
        dec_imm       = imm_i;
        dec_alu_fn    = 4'b0001;
        dec_regwrite  = 1'b1;
        dec_memtoreg  = MTR_PCP4;
        dec_membranch = MB_JALR;
        dec_alu_ctrl  = AC_JUMP;
      end
      OP_LOAD: begin
        dec_alu_src  = 3'b010;
        dec_imm      = imm_i;
        dec_alu_fn   = {1'b0, funct3};
        dec_regwrite = 1'b1;
        dec_memrw    = MRW_READ;
        dec_memtoreg = MTR_MEM;
        dec_alu_ctrl = AC_LOAD;
      end
      OP_ALUI: begin
        dec_alu_src  = 3'b010;
        dec_imm      = imm_i;
        dec_alu_fn   = {1'b0, funct3};
        dec_regwrite = 1'b1;
      end
      OP_BRANCH: begin
        dec_alu_src  = 3'b011;
        dec_imm      = imm_b;
        dec_alu_fn   = {1'b0, funct3};
        dec_alu_ctrl = AC_COMPARE;
        // Unsigned compares reuse lt/ge; alu_fn carries the signedness.
        case (funct3)
          3'b000:         dec_membranch = MB_EQ;
          3'b001:         dec_membranch = MB_NE;
          3'b100, 3'b110: dec_membranch = MB_LT;
          3'b101, 3'b111: dec_membranch = MB_GE;
          default:        dec_membranch = MB_NONE;
        endcase
      end
      OP_STORE: begin
        dec_alu_src  = 3'b010;
        dec_imm      = imm_s;
        dec_alu_fn   = {1'b0, funct3};
        dec_memrw    = MRW_WRITE;
        dec_wreg     = 5'd0;
        dec_alu_ctrl = AC_STORE;
      end
      OP_RTYPE: begin
        dec_alu_src  = 3'b011;
        dec_alu_fn   = {if_inst[30], funct3};
        dec_regwrite = 1'b1;
      end
      default: begin
        dec_wreg = 5'd0;
      end
    endcase
  end

  // rs1 is always checked (conservative for U/J forms); rs2 only where it is a real source.
  assign uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_RTYPE);
  assign hazard   = if_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1_addr) || (uses_rs2 && (ex_rd == rs2_addr)));
  assign hold     = ex_valid_q && !ex_ready;
  assign if_ready = !rst && !hazard && !flush && (!ex_valid_q || ex_ready);
  assign accept   = if_valid && if_ready;

  assign fwd_rs1 = fwd_pick(rs1_addr, rf_rdata1, wb_we, wb_rd, wb_data);
  assign fwd_rs2 = fwd_pick(rs2_addr, rf_rdata2, wb_we, wb_rd, wb_data);
  assign ref_rs1 = fwd_pick(ex_inst_q[19:15], ex_rs1_data_q, wb_we, wb_rd, wb_data);
  assign ref_rs2 = fwd_pick(ex_inst_q[24:20], ex_rs2_data_q, wb_we, wb_rd, wb_data);

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_pcp4_d      = ex_pcp4_q;
    ex_imm_d       = ex_imm_q;
    ex_rs1_data_d  = ex_rs1_data_q;
    ex_rs2_data_d  = ex_rs2_data_q;
    ex_inst_d      = ex_inst_q;
    ex_funct7_d    = ex_funct7_q;
    ex_wreg_d      = ex_wreg_q;
    ex_alu_fn_d    = ex_alu_fn_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memtoreg_d  = ex_memtoreg_q;
    ex_memrw_d     = ex_memrw_q;
    ex_membranch_d = ex_membranch_q;
    ex_alu_ctrl_d  = ex_alu_ctrl_q;
    ex_alu_src_d   = ex_alu_src_q;
    if (rst) begin
      ex_valid_d     = 1'b0;
      ex_pc_d        = '0;
      ex_pcp4_d      = '0;
      ex_imm_d       = '0;
      ex_rs1_data_d  = '0;
      ex_rs2_data_d  = '0;
      ex_inst_d      = '0;
      ex_funct7_d    = '0;
      ex_wreg_d      = '0;
      ex_alu_fn_d    = '0;
      ex_regwrite_d  = 1'b0;
      ex_memtoreg_d  = '0;
      ex_memrw_d     = '0;
      ex_membranch_d = '0;
      ex_alu_ctrl_d  = '0;
      ex_alu_src_d   = '0;
    end else if (flush) begin
      ex_valid_d = 1'b0;
    end else if (hold) begin
      ex_rs1_data_d = ref_rs1;
      ex_rs2_data_d = ref_rs2;
    end else if (accept) begin
      ex_valid_d     = 1'b1;
      ex_pc_d        = if_pc;
      ex_pcp4_d      = if_pcp4;
      ex_imm_d       = dec_imm;
      ex_rs1_data_d  = fwd_rs1;
      ex_rs2_data_d  = fwd_rs2;
      ex_inst_d      = if_inst;
      ex_funct7_d    = if_inst[31:25];
      ex_wreg_d      = dec_wreg;
      ex_alu_fn_d    = dec_alu_fn;
      ex_regwrite_d  = dec_regwrite;
      ex_memtoreg_d  = dec_memtoreg;
      ex_memrw_d     = dec_memrw;
      ex_membranch_d = dec_membranch;
      ex_alu_ctrl_d  = dec_alu_ctrl;
      ex_alu_src_d   = dec_alu_src;
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
    end else if (if_valid && !if_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    ex_valid_q     <= ex_valid_d;
    ex_pc_q        <= ex_pc_d;
    ex_pcp4_q      <= ex_pcp4_d;
    ex_imm_q       <= ex_imm_d;
    ex_rs1_data_q  <= ex_rs1_data_d;
    ex_rs2_data_q  <= ex_rs2_data_d;
    ex_inst_q      <= ex_inst_d;
    ex_funct7_q    <= ex_funct7_d;
    ex_wreg_q      <= ex_wreg_d;
    ex_alu_fn_q    <= ex_alu_fn_d;
    ex_regwrite_q  <= ex_regwrite_d;
    ex_memtoreg_q  <= ex_memtoreg_d;
    ex_memrw_q     <= ex_memrw_d;
    ex_membranch_q <= ex_membranch_d;
    ex_alu_ctrl_q  <= ex_alu_ctrl_d;
    ex_alu_src_q   <= ex_alu_src_d;
    stall_cnt_q    <= stall_cnt_d;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic ex_illegal_q, ex_illegal_d;

  assign dec_illegal = !((opcode == OP_LUI)    || (opcode == OP_AUIPC) || (opcode == OP_JAL)   ||
                         (opcode == OP_JALR)   || (opcode == OP_BRANCH) || (opcode == OP_LOAD) ||
                         (opcode == OP_STORE)  || (opcode == OP_ALUI)  || (opcode == OP_RTYPE));

  always_comb begin
    ex_illegal_d = ex_illegal_q;
    if (rst) begin
      ex_illegal_d = 1'b0;
    end else if (!flush && !hold && accept) begin
      ex_illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    ex_illegal_q <= ex_illegal_d;
  end

  assign ex_illegal = ex_illegal_q;
`endif

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_pcp4      = ex_pcp4_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_inst      = ex_inst_q;
  assign ex_funct7    = ex_funct7_q;
  assign ex_wreg      = ex_wreg_q;
  assign ex_alu_fn    = ex_alu_fn_q;
  assign ex_regwrite  = ex_regwrite_q;
  assign ex_memtoreg  = ex_memtoreg_q;
  assign ex_memrw     = ex_memrw_q;
  assign ex_membranch = ex_membranch_q;
  assign ex_alu_ctrl  = ex_alu_ctrl_q;
  assign ex_alu_src   = ex_alu_src_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/decode_fwd.md
# decode_fwd

Parametrised successor to the RV32I ID stage of the 5-stage pipeline, sitting between fetch and EX. It decodes one instruction per cycle into the EX control bundle and reads operands with multi-port writeback forwarding. It adds a valid/ready handshake on both sides, a load-use interlock that inserts bubbles, and operand refresh while EX holds the stage. A saturating stall counter is included for performance monitoring.

## Interface
- XLEN, 32, datapath width; instruction width is fixed at 32.
- FWD_PORTS, 2, number of writeback forwarding sources; port 0 has highest priority.
- STALL_CNT_W, 16, width of the saturating interlock/backpressure stall counter.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards the held instruction and the incoming instruction this cycle.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage accepts the instruction this cycle.
- if_pc, if_pcp4  in  XLEN each  PC and PC+4 of the instruction.
- if_inst  in  32  instruction word.
- rs1_addr, rs2_addr  out  5 each  combinational, if_inst[19:15] and if_inst[24:20].
- rf_rdata1, rf_rdata2  in  XLEN each  register file read data, same cycle.
- wb_we  in  FWD_PORTS  writeback enables.
- wb_rd  in  5*FWD_PORTS  writeback destinations, packed, port i at [5i+4:5i].
- wb_data  in  XLEN*FWD_PORTS  writeback data, packed.
- ex_is_load, ex_rd  in  1, 5  instruction currently in EX is a load and its rd.
- ex_valid  out  1  bundle valid; ex_ready  in  1  EX consumes the bundle.
- ex_pc, ex_pcp4, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN each.
- ex_inst  out  32; ex_funct7  out  7; ex_wreg  out  5; ex_alu_fn  out  4; ex_regwrite  out  1.
- ex_memtoreg  out  2; ex_memrw  out  2; ex_membranch  out  3; ex_alu_ctrl  out  3; ex_alu_src  out  3.
- ex_illegal  out  1  present only with DECODE_ILLEGAL_TRAP_EN.
- stall_cnt  out  STALL_CNT_W  number of cycles with if_valid=1 and if_ready=0, saturating.

## Operation
- Encodings:
  - memtoreg: ALU 00, mem 01, PC+4 10.
  - memrw: none 00, write 01, read 10.
  - membranch: none 000, eq 001, ne 010, lt 011, ge 100, jal 110, jalr 111.
  - alu_ctrl: normal 000, compare 001, no-ALU 010, jump 011, load 101, store 110.
- Per-opcode decode (alu_src / imm / alu_fn / regwrite):
  - LUI: 000 / U / 0 / 1.
  - AUIPC: 100 / U / 0 / 1.
  - JAL: 100 / J / 0000 / 1, memtoreg 10.
  - JALR: 010 / I / 0001 / 1, memtoreg 10.
  - LOAD: 010 / I / {0,f3} / 1, memrw 10, memtoreg 01.
  - ALUI: 010 / I / {0,f3} / 1.
  - BRANCH: 011 / B / {0,f3} / 0; membranch eq/ne/lt/ge (unsigned variants share lt/ge and are distinguished by alu_fn).
  - STORE: 010 / S / {0,f3} / 0, memrw 01, wreg 0.
  - R-type: 011 / 0 / {inst[30],f3} / 1, memrw 00.
- Any other opcode is illegal: all control fields are 0 and regwrite is 0 (a bubble that still advances).
- Immediates are sign-extended to XLEN; U-immediate is {inst[31:12],12'b0}, sign-extended above bit 31 when XLEN>32.
- Operand capture: for each rs, the lowest-index wb port with we=1, rd==rs, and rs!=0 supplies the data; otherwise rf_rdata is used. rs==0 always yields 0.
- Hold refresh: while ex_valid=1 and ex_ready=0, any wb port matching the held rs (rs!=0) overwrites ex_rsN_data, using the same priority.
- Load-use hazard: if_valid, ex_is_load, ex_rd!=0, and ex_rd equals rs1 or rs2 of if_inst (rs2 checked only for BRANCH/STORE/R-type).
- On a hazard: if_ready=0, and if EX frees the slot, ex_valid goes to 0 (bubble).

## Timing
- Latency is 1: an instruction accepted at edge N appears on the ex_* outputs after edge N.
- if_ready = !hazard && !flush && (!ex_valid || ex_ready).
- Accept occurs when if_valid && if_ready. A held bundle keeps all fields stable except the refreshed operands.
- When ex_ready=1 and there is no accept, ex_valid goes to 0 next cycle.
- flush=1: ex_valid goes to 0 next cycle, and no instruction is accepted regardless of other inputs.
- Priority is rst > flush > hold > accept.
- rst=1: all ex_* outputs and stall_cnt are 0 next cycle; if_ready=0 during the rst cycle. Reset mid-hold discards the bundle.
- stall_cnt increments when if_valid && !if_ready && !rst and holds at all-ones once saturated.
- Hazard and hold asserted simultaneously count as one stall cycle.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - ex_illegal exists; illegal opcodes advance with ex_illegal=1 and all other controls 0.
  - ex_illegal resets to 0.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - The port is absent.
  - Illegal opcodes are decoded silently as bubbles with ex_inst preserved.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with if_valid=1.
  - Required: ex_valid=0, all ex_* =0, stall_cnt=0, if_ready=0.
- Basic decode:
  - Stimulus: addi x5,x0,-1 (0xFFF00293) with ex_ready=1.
  - Required, next cycle: ex_valid=1, ex_imm=0xFFFFFFFF, ex_wreg=5, ex_alu_src=010, ex_regwrite=1.
- Forward priority:
  - Stimulus: add x3,x1,x2 with wb0 (rd=1, data 0xA) and wb1 (rd=1, data 0xB) both writing; rf_rdata2=7.
  - Required: ex_rs1_data=0xA, ex_rs2_data=7.
  - Stimulus: the same with rs1=x0 and wb0 rd=0.
  - Required: ex_rs1_data=0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_rd=4, incoming sw x4,0(x2).
  - Required: one bubble (ex_valid=0), if_ready=0, stall_cnt=1. After ex_is_load drops, the sw is accepted with ex_memrw=01.
- Hold refresh:
  - Stimulus: bundle held 3 cycles with ex_ready=0; wb0 writes rs2 with 0x55 in cycle 2.
  - Required: ex_rs2_data=0x55 from cycle 3, all other fields unchanged, stall_cnt=3.
- Flush and illegal:
  - Stimulus: flush during hold.
  - Required: ex_valid=0 next cycle.
  - Stimulus: opcode 0x7F with DECODE_ILLEGAL_TRAP_EN defined.
  - Required: ex_illegal=1, ex_regwrite=0.
